// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the memory access controller slice.
package mem_access_pkg;

  localparam int MEM_DEPTH_DFLT = 129;
  localparam int ADR_W_DFLT     = 10;
  localparam int LEN_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DRAIN
  } ctrlState_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Loadable burst address counter that wraps at MEM_DEPTH and tracks the
// number of words still to be issued after the current one.
module mem_addr_gen
  import mem_access_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DFLT,
  parameter int ADR_W     = ADR_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [ADR_W-1:0] startAdr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [ADR_W-1:0] adr_o,
  output logic             last_o
);

  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(MEM_DEPTH - 1);

  logic [ADR_W-1:0] adr_q, adr_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  // Out-of-range start addresses are folded into the memory before use;
  // the remaining count holds at zero once the final word has been issued.
  always_comb begin
    adr_d = adr_q;
    rem_d = rem_q;
    if (load_i) begin
      adr_d = ADR_W'(32'(startAdr_i) % MEM_DEPTH);
      rem_d = len_i;
    end else if (adv_i) begin
      adr_d = (adr_q == LAST_ADR) ? '0 : adr_q + ADR_W'(1);
      if (rem_q != '0) begin
        rem_d = rem_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q <= '0;
      rem_q <= '0;
    end else begin
      adr_q <= adr_d;
      rem_q <= rem_d;
    end
  end

  assign adr_o  = adr_q;
  assign last_o = (rem_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates single-byte writes (priority) and burst reads onto one
// registered-read memory port.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DFLT,
  parameter int ADR_W     = ADR_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [ADR_W-1:0] rd_req_adr,
  input  logic [LEN_W-1:0] rd_req_len,
  output logic             rd_data_valid,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [7:0]       wr_data,
  output logic             mem_w_r_en,
  output logic [ADR_W-1:0] mem_adr,
  output logic [7:0]       mem_write_data,
  input  logic [31:0]      mem_read_data
);

  ctrlState_e       state_q, state_d;
  logic [ADR_W-1:0] wrAdr_q, wrAdr_d;
  logic [7:0]       wrData_q, wrData_d;
  logic             rdValid_q, rdValid_d;
  logic             rdLast_q, rdLast_d;
  logic             genLoad, genAdv, genLast;
  logic [ADR_W-1:0] genAdr;

  mem_addr_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADR_W     (ADR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (genLoad),
    .adv_i      (genAdv),
    .startAdr_i (rd_req_adr),
    .len_i      (rd_req_len),
    .adr_o      (genAdr),
    .last_o     (genLast)
  );

  // Read data lags the issued address by one cycle, so valid/last are the
  // issue-cycle conditions delayed by one register stage.
  always_comb begin
    state_d   = state_q;
    wrAdr_d   = wrAdr_q;
    wrData_d  = wrData_q;
    genLoad   = 1'b0;
    genAdv    = 1'b0;
    rdValid_d = (state_q == RD_ISSUE);
    rdLast_d  = (state_q == RD_ISSUE) && genLast;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          wrAdr_d  = ADR_W'(32'(wr_adr) % MEM_DEPTH);
          wrData_d = wr_data;
          state_d  = WR;
        end else if (rd_req_valid) begin
          genLoad = 1'b1;
          state_d = RD_ISSUE;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD_ISSUE: begin
        genAdv = 1'b1;
        if (genLast) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wrAdr_q   <= '0;
      wrData_q  <= '0;
      rdValid_q <= 1'b0;
      rdLast_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrAdr_q   <= wrAdr_d;
      wrData_q  <= wrData_d;
      rdValid_q <= rdValid_d;
      rdLast_q  <= rdLast_d;
    end
  end

  assign rd_req_ready   = (state_q == IDLE);
  assign wr_ready       = (state_q == IDLE);
  assign mem_w_r_en     = (state_q == WR);
  assign mem_write_data = (state_q == WR) ? wrData_q : 8'h00;
  assign mem_adr        = (state_q == WR)       ? wrAdr_q :
                          (state_q == RD_ISSUE) ? genAdr  : '0;
  assign rd_data_valid  = rdValid_q;
  assign rd_last        = rdLast_q;
  assign rd_data        = mem_read_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a registered-read memory model.
module tb_mem_access_ctrl;

  localparam int DEPTH = 129;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } rdExp_t;

  typedef struct {
    logic [9:0] adr;
    logic [7:0] data;
    int         cyc;
  } wrExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [9:0]  rd_req_adr;
  logic [3:0]  rd_req_len;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_adr;
  logic [7:0]  wr_data;
  logic        mem_w_r_en;
  logic [9:0]  mem_adr;
  logic [7:0]  mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [DEPTH];
  rdExp_t      rdQ[$];
  wrExp_t      wrQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          wroteFive = 1'b0;

  mem_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_adr     (rd_req_adr),
    .rd_req_len     (rd_req_len),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_adr         (wr_adr),
    .wr_data        (wr_data),
    .mem_w_r_en     (mem_w_r_en),
    .mem_adr        (mem_adr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with one-cycle registered read; writes land in the low byte.
  always @(posedge clk) begin
    if (int'(mem_adr) < DEPTH) begin
      mem_read_data <= mem[mem_adr];
      if (mem_w_r_en) mem[mem_adr][7:0] <= mem_write_data;
    end else begin
      mem_read_data <= 32'hDEAD_BEEF;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] expData(input int a);
    if (a == 5 && wroteFive) return 32'hC0DE_00A7;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Read-data monitor: every valid beat must match the next expected word.
  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (rdQ.size() == 0) begin
        checkOutput("unexpected_rd_beat", {31'd0, rd_data_valid}, 32'd0);
      end else begin
        rdExp_t e;
        e = rdQ.pop_front();
        checkOutput("rd_data", rd_data, e.data);
        checkOutput("rd_last", {31'd0, rd_last}, {31'd0, e.last});
        checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Write monitor: each write strobe cycle must match one expected write.
  always @(negedge clk) begin
    if (mem_w_r_en) begin
      if (wrQ.size() == 0) begin
        checkOutput("unexpected_wr_strobe", {31'd0, mem_w_r_en}, 32'd0);
      end else begin
        wrExp_t w;
        w = wrQ.pop_front();
        checkOutput("wr_adr", {22'd0, mem_adr}, {22'd0, w.adr});
        checkOutput("wr_data", {24'd0, mem_write_data}, {24'd0, w.data});
        checkOutput("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  // Idle/non-write invariants on the memory-side outputs.
  always @(negedge clk) begin
    if (!mem_w_r_en) checkOutput("wdata_zero_outside_wr", {24'd0, mem_write_data}, 32'd0);
    if (wr_ready) checkOutput("idle_mem_adr_zero", {22'd0, mem_adr}, 32'd0);
    checkOutput("ready_match", {31'd0, wr_ready}, {31'd0, rd_req_ready});
  end

  task automatic pushRead(input int adr, input int len, input int base);
    for (int i = 0; i <= len; i++) begin
      rdExp_t e;
      e.data = expData(((adr % DEPTH) + i) % DEPTH);
      e.last = (i == len);
      e.cyc  = base + 2 + i;
      rdQ.push_back(e);
    end
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!rd_req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rd_req_ready) checkOutput(name, 32'd0, 32'd1);
  endtask

  task automatic applyReadStimulus(input int adr, input int len);
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_adr   = 10'(adr);
    rd_req_len   = 4'(len);
    waitReady("rd_ready_timeout");
    pushRead(adr, len, cyc);
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
  endtask

  task automatic applyWriteStimulus(input int adr, input logic [7:0] data, input int expAdr);
    wrExp_t w;
    int c;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_adr   = 10'(adr);
    wr_data  = data;
    waitReady("wr_ready_timeout");
    c = cyc;
    w.adr = 10'(expAdr); w.data = data; w.cyc = c + 1;
    wrQ.push_back(w);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr_ready_busy_t1", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("wr_ready_back_t2", {31'd0, wr_ready}, 32'd1);
    checkOutput("wr_ready_cycle", 32'(cyc), 32'(c + 2));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c;
    wrExp_t w;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    rst = 1'b1;
    rd_req_valid = 1'b0; rd_req_adr = '0; rd_req_len = '0;
    wr_valid = 1'b0; wr_adr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_ready", {31'd0, rd_req_ready}, 32'd1);
    checkOutput("reset_mem_w_r_en", {31'd0, mem_w_r_en}, 32'd0);
    checkOutput("reset_rd_data_valid", {31'd0, rd_data_valid}, 32'd0);
    checkOutput("reset_rd_last", {31'd0, rd_last}, 32'd0);
    rst = 1'b0;

    applyWriteStimulus(5, 8'hA7, 5);
    wroteFive = 1'b1;
    applyReadStimulus(10, 3);
    applyReadStimulus(127, 3);
    applyReadStimulus(5, 0);

    // Simultaneous write and read: write first, read accepted two cycles later.
    @(negedge clk);
    wr_valid = 1'b1; wr_adr = 10'd200; wr_data = 8'h3C;
    rd_req_valid = 1'b1; rd_req_adr = 10'd1000; rd_req_len = 4'd1;
    waitReady("both_ready_timeout");
    c = cyc;
    w.adr = 10'd71; w.data = 8'h3C; w.cyc = c + 1;
    wrQ.push_back(w);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("both_rd_blocked", {31'd0, rd_req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("both_rd_accept_ready", {31'd0, rd_req_ready}, 32'd1);
    checkOutput("both_rd_accept_cycle", 32'(cyc), 32'(c + 2));
    pushRead(1000, 1, cyc);
    @(posedge clk);
    #1 rd_req_valid = 1'b0;

    applyReadStimulus(0, 15);

    // Reset in the middle of a len=7 burst: only two words may appear.
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_adr = 10'd20; rd_req_len = 4'd7;
    waitReady("rst_burst_ready_timeout");
    c = cyc;
    pushRead(20, 1, c);
    rdQ[1].last = 1'b0;
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
    while (cyc < c + 3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_rd_data_valid", {31'd0, rd_data_valid}, 32'd0);
    checkOutput("midrst_rd_last", {31'd0, rd_last}, 32'd0);
    checkOutput("midrst_mem_w_r_en", {31'd0, mem_w_r_en}, 32'd0);
    checkOutput("midrst_mem_adr", {22'd0, mem_adr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_req_valid = 1'b1; rd_req_adr = 10'd0; rd_req_len = 4'd0;
    checkOutput("post_rst_ready", {31'd0, rd_req_ready}, 32'd1);
    pushRead(0, 0, cyc);
    @(posedge clk);
    #1 rd_req_valid = 1'b0;

    for (int i = 0; i < 40 && (rdQ.size() != 0 || wrQ.size() != 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);
    checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: MEM_DEPTH, 129, number of 32-bit words in the attached memory.
REQ-002 Parameter: ADR_W, 10, memory address width.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: rd_req_valid  in  1  burst-read request present.
REQ-006 Port: rd_req_ready  out  1  controller can accept a request (read or write).
REQ-007 Port: rd_req_adr  in  ADR_W  burst start word address.
REQ-008 Port: rd_req_len  in  4  burst length minus one (0 = 1 word, 15 = 16 words).
REQ-009 Port: rd_data_valid  out  1  rd_data carries one burst word this cycle.
REQ-010 Port: rd_data  out  32  read word, passthrough of mem_read_data.
REQ-011 Port: rd_last  out  1  final word of the burst, qualified by rd_data_valid.
REQ-012 Port: wr_valid  in  1  single-byte write request present.
REQ-013 Port: wr_ready  out  1  write request accepted when high with wr_valid.
REQ-014 Port: wr_adr  in  ADR_W  write word address.
REQ-015 Port: wr_data  in  8  write data.
REQ-016 Port: mem_w_r_en  out  1  to memory: 1 = write, 0 = read.
REQ-017 Port: mem_adr  out  ADR_W  to memory address.
REQ-018 Port: mem_write_data  out  8  to memory write data.
REQ-019 Port: mem_read_data  in  32  from memory, registered, valid one cycle after the read address edge.

Function
REQ-020 FSM states: IDLE, WR, RD_ISSUE, RD_DRAIN; all outputs except rd_data registered or decoded from registered state.
REQ-021 rd_req_ready and wr_ready high only in IDLE; low in every other state.
REQ-022 IDLE, wr_valid=1 (write priority regardless of rd_req_valid): capture wr_adr/wr_data, go WR.
REQ-023 IDLE, wr_valid=0, rd_req_valid=1: capture rd_req_adr as address counter, rd_req_len as remaining count, go RD_ISSUE.
REQ-024 WR (one cycle): mem_w_r_en=1, mem_adr=captured address, mem_write_data=captured byte; next state IDLE.
REQ-025 RD_ISSUE: mem_w_r_en=0, mem_adr=address counter; each cycle counter increments, remaining decrements; leave to RD_DRAIN after the cycle with remaining=0.
REQ-026 Address counter wraps MEM_DEPTH-1 -> 0; captured addresses >= MEM_DEPTH are reduced modulo MEM_DEPTH before use.
REQ-027 rd_data_valid asserted exactly one cycle after each RD_ISSUE cycle; rd_last on the word issued with remaining=0.
REQ-028 RD_DRAIN (one cycle): delivers final word, mem_w_r_en=0; next state IDLE.
REQ-029 Latency: request accepted at cycle T -> first word at T+2, last word at T+N+1 (N = len+1), IDLE again at T+N+2; write completes in memory at end of T+1.
REQ-030 Requests presented outside IDLE are ignored (not captured); requester holds them until ready.
REQ-031 Outside WR, mem_w_r_en=0 and mem_write_data=0; in IDLE mem_adr=0.

Reset
REQ-032 rst asserted (any time, including mid-burst): state IDLE, counters 0, mem_w_r_en=0, mem_adr=0, mem_write_data=0, rd_data_valid=0, rd_last=0; in-flight burst discarded, no further words delivered.
REQ-033 First request acceptable in the first cycle after rst deasserts.

Structure
REQ-034 Shared package mem_access_pkg holds state enum, MEM_DEPTH default, ADR_W, length width.
REQ-035 One sub-module mem_addr_gen: loadable address counter with MEM_DEPTH wrap and remaining-count/last flag.

Verification
REQ-036 Write adr=5 data=0xA7 -> mem_w_r_en=1, mem_adr=5, mem_write_data=0xA7 for exactly one cycle at T+1; ready back high at T+2.
REQ-037 Read adr=10 len=3 -> mem_adr 10,11,12,13 at T+1..T+4; rd_data_valid T+2..T+5; rd_last only at T+5.
REQ-038 Read adr=127 len=3 with MEM_DEPTH=129 -> addresses 127,128,0,1.
REQ-039 wr_valid and rd_req_valid both high in IDLE -> write executes first; read accepted at T+2.
REQ-040 rst pulsed during burst at T+3 of len=7 -> rd_data_valid=0 next cycle, IDLE, mem_w_r_en=0.
REQ-041 len=0 read adr=0 -> single word at T+2 with rd_last=1.
